// File: rtl/int_ctrl_if.sv
// Pin and FSM-facing signal bundle for the 6502C interrupt controller.
// The master side drives pins and FSM handshakes; the slave side is int_ctrl.
interface int_ctrl_if;
    logic        res_n;
    logic        nmi_n;
    logic        irq_n;
    logic        statusI;
    logic        T1now;
    logic        rstHandled;
    logic        nmiHandled;
    logic        irqHandled;
    logic        resPend;
    logic        nmiPend;
    logic        irqPend;
    logic [1:0]  activeInt;
    logic [15:0] vecAddr;

    modport master (
        output res_n, nmi_n, irq_n, statusI, T1now,
        output rstHandled, nmiHandled, irqHandled,
        input  resPend, nmiPend, irqPend, activeInt, vecAddr
    );

    modport slave (
        input  res_n, nmi_n, irq_n, statusI, T1now,
        input  rstHandled, nmiHandled, irqHandled,
        output resPend, nmiPend, irqPend, activeInt, vecAddr
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises RES/NMI/IRQ pins, qualifies them, commits the
// highest-priority request at instruction boundaries and supplies its vector.
module int_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] NMI_VEC     = 16'hFFFA,
    parameter logic [15:0] RES_VEC     = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
    input logic      phi1,
    input logic      rst,
    int_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        INT_NONE = 2'b00,
        INT_IRQ  = 2'b01,
        INT_NMI  = 2'b10,
        INT_RES  = 2'b11
    } intState_t;

    intState_t state, stateNext;

    logic [SYNC_STAGES-1:0] resSync, nmiSync, irqSync;
    logic                   nmiDly;
    logic                   resSn, nmiSn, irqSn, nmiEdge;
    logic                   resPendQ, nmiPendQ, irqPendQ, irqHold;
    logic                   retire;

    assign resSn   = resSync[SYNC_STAGES-1];
    assign nmiSn   = nmiSync[SYNC_STAGES-1];
    assign irqSn   = irqSync[SYNC_STAGES-1];
    assign nmiEdge = nmiDly & ~nmiSn;

    always_ff @(posedge phi1) begin
        if (rst) begin
            resSync <= '1;
            nmiSync <= '1;
            irqSync <= '1;
            nmiDly  <= 1'b1;
        end else begin
            resSync <= {resSync[SYNC_STAGES-2:0], bus.res_n};
            nmiSync <= {nmiSync[SYNC_STAGES-2:0], bus.nmi_n};
            irqSync <= {irqSync[SYNC_STAGES-2:0], bus.irq_n};
            nmiDly  <= nmiSn;
        end
    end

    // A held-low RES keeps resPend set even across rstHandled; an NMI edge beats a
    // same-cycle nmiHandled. irqHold masks IRQ while the I flag write catches up.
    always_ff @(posedge phi1) begin
        if (rst) begin
            resPendQ <= 1'b0;
            nmiPendQ <= 1'b0;
            irqPendQ <= 1'b0;
            irqHold  <= 1'b0;
        end else begin
            if (!resSn)
                resPendQ <= 1'b1;
            else if (bus.rstHandled)
                resPendQ <= 1'b0;

            if (nmiEdge)
                nmiPendQ <= 1'b1;
            else if (bus.nmiHandled)
                nmiPendQ <= 1'b0;

            irqPendQ <= ~irqSn & ~bus.statusI & ~irqHold;
            irqHold  <= bus.irqHandled;
        end
    end

    always_ff @(posedge phi1) begin
        if (rst)
            state <= INT_NONE;
        else
            state <= stateNext;
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            INT_RES:  retire = bus.rstHandled;
            INT_NMI:  retire = bus.nmiHandled;
            INT_IRQ:  retire = bus.irqHandled;
            default:  retire = 1'b0;
        endcase
    end

    // Retire takes precedence over a same-edge commit; the commit waits for the next T1now.
    always_comb begin
        stateNext = state;
        if (retire) begin
            stateNext = INT_NONE;
        end else if (bus.T1now && state == INT_NONE) begin
            if (resPendQ)
                stateNext = INT_RES;
            else if (nmiPendQ)
                stateNext = INT_NMI;
            else if (irqPendQ)
                stateNext = INT_IRQ;
            else
                stateNext = INT_NONE;
        end
    end

    always_comb begin
        case (state)
            INT_RES: bus.vecAddr = RES_VEC;
            INT_NMI: bus.vecAddr = NMI_VEC;
            default: bus.vecAddr = IRQ_VEC;
        endcase
    end

    assign bus.resPend   = resPendQ;
    assign bus.nmiPend   = nmiPendQ;
    assign bus.irqPend   = irqPendQ;
    assign bus.activeInt = state;

endmodule
